// File: rtl/codificador_bcd_serial.sv
// codificador_bcd_serial
//   Sequential BCD-to-binary encoder using reverse double-dabble: each clock the
//   {bcd, bin} pair is shifted right by one bit. After the shift, 3 is subtracted
//   from every BCD nibble that is >= 8. One iteration per clock, 4*DIGITS iterations
//   per conversion.
//
// Parameters
//   DIGITS  number of packed BCD digits on bcd_in (>= 1)
//   BIN_W   width of bin_out (>= ceil(log2(10**DIGITS)), <= 4*DIGITS)
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    conversion request, sampled only while idle
//   bcd_in   packed BCD, digit 0 in [3:0]; only sampled on the accepting edge
//   busy     high from the accepting edge until the result is presented
//   valid    one-cycle pulse; bin_out and err are meaningful while high
//   bin_out  binary result, held until the next result
//   err      invalid-digit flag (always 0 unless BCD_DIGIT_CHECK_EN is defined)
//
// Configuration
//   BCD_DIGIT_CHECK_EN  when defined, a request carrying any nibble > 9 bypasses
//                       the conversion: it returns bin_out=0 with err=1 one edge later.
module codificador_bcd_serial #(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned BIN_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  valid,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int unsigned NBits = 4 * DIGITS;
  localparam int unsigned CntW  = $clog2(NBits);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q;
  logic [NBits-1:0]  bcd_q;
  logic [NBits-1:0]  bin_q;
  logic [CntW-1:0]   cnt_q;
  logic [NBits-1:0]  bcd_shift;
  logic [NBits-1:0]  bin_shift;
  logic              last_iter;

  assign last_iter = (cnt_q == CntW'(NBits - 1));

  // One reverse double-dabble step on {bcd_q, bin_q}.
  always_comb begin
    bin_shift = {bcd_q[0], bin_q[NBits-1:1]};
    bcd_shift = bcd_q >> 1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_shift[4*i +: 4] >= 4'd8) begin
        bcd_shift[4*i +: 4] = bcd_shift[4*i +: 4] - 4'd3;
      end
    end
  end

  // Bits of the working register above BIN_W are dropped without an overflow flag.
  if (BIN_W < NBits) begin : g_trunc
    logic unused_hi;
    assign unused_hi = ^bin_shift[NBits-1:BIN_W];
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic bad_digit;
  always_comb begin
    bad_digit = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      bin_out <= '0;
`ifdef BCD_DIGIT_CHECK_EN
      err     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
`ifdef BCD_DIGIT_CHECK_EN
            if (bad_digit) begin
              // Reject without converting; busy is never raised.
              bin_out <= '0;
              err     <= 1'b1;
              valid   <= 1'b1;
              state_q <= StDone;
            end else
`endif
            begin
              bcd_q   <= bcd_in;
              bin_q   <= '0;
              cnt_q   <= '0;
              busy    <= 1'b1;
              state_q <= StShift;
            end
          end
        end
        StShift: begin
          bcd_q <= bcd_shift;
          bin_q <= bin_shift;
          cnt_q <= cnt_q + CntW'(1);
          if (last_iter) begin
            bin_out <= bin_shift[BIN_W-1:0];
            valid   <= 1'b1;
            busy    <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
            err     <= 1'b0;
`endif
            state_q <= StDone;
          end
        end
        StDone: begin
          valid   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifndef BCD_DIGIT_CHECK_EN
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_codificador_bcd_serial.sv
module tb_codificador_bcd_serial;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] bcd_in;
  logic       busy;
  logic       valid;
  logic [6:0] bin_out;
  logic       err;

  int n_vec;
  int n_fail;

  codificador_bcd_serial #(
    .DIGITS (2),
    .BIN_W  (7)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .valid   (valid),
    .bin_out (bin_out),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] bcd;
    int         bin;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Full conversion starting just after a rising edge. With noise set, start is
  // held high with bcd_in=77 during the conversion; that must not be queued.
  task automatic run_conv(input logic [7:0] bcd, input int exp, input bit noise);
    start  = 1'b1;
    bcd_in = bcd;
    @(posedge clk); #1;
    check("accept_busy", busy, 1);
    check("accept_valid", valid, 0);
    start  = noise;
    bcd_in = noise ? 8'h77 : 8'h00;
    for (int j = 1; j <= 8; j++) begin
      @(posedge clk); #1;
      if (j < 8) begin
        if (busy !== 1'b1 || valid !== 1'b0) begin
          check("shift_busy", busy, 1);
          check("shift_valid", valid, 0);
        end
      end else begin
        check("done_valid", valid, 1);
        check("done_busy", busy, 0);
        check("done_bin", bin_out, exp);
        check("done_err", err, 0);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    check("pulse_end", valid, 0);
    check("hold_bin", bin_out, exp);
    if (noise) begin
      for (int j = 0; j < 4; j++) begin
        @(posedge clk); #1;
        if (busy !== 1'b0 || valid !== 1'b0) begin
          check("noqueue_busy", busy, 0);
          check("noqueue_valid", valid, 0);
        end
      end
      check("noqueue_bin", bin_out, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec  = 0;
    n_fail = 0;
    vecs[0] = '{8'h45, 45};
    vecs[1] = '{8'h00, 0};
    vecs[2] = '{8'h09, 9};
    vecs[3] = '{8'h10, 10};
    vecs[4] = '{8'h99, 99};
    vecs[5] = '{8'h37, 37};
    vecs[6] = '{8'h80, 80};
    vecs[7] = '{8'h64, 64};

    // Reset held with start asserted
    rst_n  = 1'b1;
    start  = 1'b1;
    bcd_in = 8'h45;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_err", err, 0);
    check("rst_bin", bin_out, 0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);
    check("idle_valid", valid, 0);

    // Table sweep
    for (int i = 0; i < 8; i++) begin
      run_conv(vecs[i].bcd, vecs[i].bin, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("between_bin", bin_out, vecs[i].bin);
      check("between_valid", valid, 0);
    end

    // start held high during conversion is ignored
    run_conv(8'h12, 12, 1'b1);

    // Reset mid-conversion at cnt=3
    start  = 1'b1;
    bcd_in = 8'h58;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    check("abort_bin", bin_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      if (valid !== 1'b0) check("abort_novalid", valid, 0);
    end
    check("abort_idle", busy, 0);
    run_conv(8'h58, 58, 1'b0);

`ifdef BCD_DIGIT_CHECK_EN
    start  = 1'b1;
    bcd_in = 8'h3A;
    @(posedge clk); #1;
    start = 1'b0;
    check("bad_valid", valid, 1);
    check("bad_err", err, 1);
    check("bad_busy", busy, 0);
    check("bad_bin", bin_out, 0);
    @(posedge clk); #1;
    check("bad_pulse_end", valid, 0);
    run_conv(8'h21, 21, 1'b0);
`else
    // Illegal nibble converts normally with err tied low
    start  = 1'b1;
    bcd_in = 8'h3A;
    @(posedge clk); #1;
    start = 1'b0;
    check("nochk_busy", busy, 1);
    repeat (8) @(posedge clk);
    #1;
    check("nochk_valid", valid, 1);
    check("nochk_err", err, 0);
    @(posedge clk); #1;
    check("nochk_pulse_end", valid, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
